bit_serial_alu_ctrl: RTL and testbench



---
 rtl/bit_serial_alu_ctrl.sv | 110 +++++++++++
 tb/tb_bit_serial_alu_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial AND/OR/ADD/SUB sequencer: one operand bit per clock through a
// single 1-bit slice, LSB first, with a registered result and a done pulse.
module bit_serial_alu_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       operation,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             busy,
    output logic             done
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, sh_q, result_q;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt_q;
    logic             c_q, cout_q;

    logic             bit_a, bit_b, bit_bb, bit_r, sum, c_next, last, accept;
    logic [WIDTH-1:0] shifted;

    // The DONE cycle also accepts a start so back-to-back ops run every WIDTH+1 clocks.
    assign accept = start && (state_q == S_IDLE || state_q == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != S_IDLE);
        done = (state_q == S_DONE);
    end

    // 1-bit ALU slice; SUB is a + ~b + 1 with the carry flop seeded to 1.
    always_comb begin
        bit_a  = a_q[cnt_q];
        bit_b  = b_q[cnt_q];
        bit_bb = bit_b ^ (op_q == OP_SUB);
        sum    = bit_a ^ bit_bb ^ c_q;
        c_next = (bit_a & bit_bb) | (bit_a & c_q) | (bit_bb & c_q);
        case (op_q)
            OP_AND:  bit_r = bit_a & bit_b;
            OP_OR:   bit_r = bit_a | bit_b;
            default: bit_r = sum;
        endcase
        last    = (cnt_q == CW'(WIDTH - 1));
        shifted = {bit_r, sh_q[WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_AND;
            cnt_q    <= '0;
            c_q      <= 1'b0;
            sh_q     <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_q   <= a;
            b_q   <= b;
            op_q  <= operation;
            cnt_q <= '0;
            c_q   <= (operation == OP_SUB);
            sh_q  <= '0;
        end else if (state_q == S_RUN) begin
            cnt_q <= cnt_q + CW'(1);
            c_q   <= c_next;
            sh_q  <= shifted;
            if (last) begin
                result_q <= shifted;
                case (op_q)
                    OP_ADD:  cout_q <= c_next;
                    OP_SUB:  cout_q <= ~c_next;
                    default: cout_q <= 1'b0;
                endcase
            end
        end
    end

    assign result    = result_q;
    assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Directed and randomized checks of bit_serial_alu_ctrl at WIDTH=8 and WIDTH=2.
module tb_bit_serial_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] a = '0, b = '0;
    logic [1:0] op = '0;
    logic [7:0] result;
    logic       cout, busy, done;

    logic       start2 = 1'b0;
    logic [1:0] a2 = '0, b2 = '0, op2 = '0;
    logic [1:0] result2;
    logic       cout2, busy2, done2;

    int total = 0;
    int bad = 0;

    bit_serial_alu_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .operation(op),
        .result(result), .carry_out(cout), .busy(busy), .done(done)
    );

    bit_serial_alu_ctrl #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .operation(op2),
        .result(result2), .carry_out(cout2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [7:0] ia, input logic [7:0] ib, input logic [1:0] iop);
        a = ia; b = ib; op = iop; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Counts edges until done is seen, bounded at 40.
    task automatic wait_done(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!done && k < 40);
    endtask

    task automatic test_reset();
        #12;
        total++; if (result !== 8'h00) begin bad++; $display("FAIL reset_result got=%h exp=00", result); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b exp=0", cout); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    task automatic test_add_basic();
        int k;
        start_op(8'h5A, 8'h3C, 2'b10);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_e0 got=%b exp=1", busy); end
        wait_done(k);
        total++; if (k !== 8) begin bad++; $display("FAIL add_latency got=%0d exp=8", k); end
        total++; if (result !== 8'h96) begin bad++; $display("FAIL add_result got=%h exp=96", result); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL add_cout got=%b exp=0", cout); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL add_busy_done got=%b exp=1", busy); end
        tick();
        total++; if (done !== 1'b0) begin bad++; $display("FAIL add_done_fall got=%b exp=0", done); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL add_busy_fall got=%b exp=0", busy); end
        total++; if (result !== 8'h96) begin bad++; $display("FAIL add_hold got=%h exp=96", result); end
    endtask

    task automatic test_arith();
        int k;
        start_op(8'hFF, 8'h01, 2'b10);
        wait_done(k);
        total++; if ({cout, result} !== 9'h100) begin bad++; $display("FAIL add_wrap got=%b,%h exp=1,00", cout, result); end
        tick();
        start_op(8'h10, 8'h20, 2'b11);
        wait_done(k);
        total++; if ({cout, result} !== 9'h1F0) begin bad++; $display("FAIL sub_borrow got=%b,%h exp=1,f0", cout, result); end
        tick();
        start_op(8'h20, 8'h10, 2'b11);
        wait_done(k);
        total++; if ({cout, result} !== 9'h010) begin bad++; $display("FAIL sub_noborrow got=%b,%h exp=0,10", cout, result); end
        tick();
    endtask

    task automatic test_back_to_back();
        int k;
        a = 8'hF0; b = 8'h3C; op = 2'b00; start = 1'b1;
        tick();
        tick();
        op = 2'b01;
        wait_done(k);
        total++; if (k !== 7) begin bad++; $display("FAIL b2b_and_latency got=%0d exp=7", k); end
        total++; if ({cout, result} !== 9'h030) begin bad++; $display("FAIL b2b_and got=%b,%h exp=0,30", cout, result); end
        tick();
        total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL b2b_accept busy,done got=%b exp=10", {busy, done}); end
        wait_done(k);
        total++; if (k !== 8) begin bad++; $display("FAIL b2b_or_latency got=%0d exp=8", k); end
        total++; if ({cout, result} !== 9'h0FC) begin bad++; $display("FAIL b2b_or got=%b,%h exp=0,fc", cout, result); end
        start = 1'b0;
        tick();
        total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL b2b_idle busy,done got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_ignore_start();
        int k, extra;
        start_op(8'h01, 8'h01, 2'b10);
        tick();
        tick();
        a = 8'hFF; b = 8'hFF; op = 2'b00; start = 1'b1;
        tick();
        start = 1'b0; a = 8'hAA; b = 8'h55;
        wait_done(k);
        total++; if (k !== 5) begin bad++; $display("FAIL ign_latency got=%0d exp=5", k); end
        total++; if ({cout, result} !== 9'h002) begin bad++; $display("FAIL ign_result got=%b,%h exp=0,02", cout, result); end
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL ign_extra_op got=%0d exp=0", extra); end
    endtask

    task automatic test_rst_mid();
        int k, extra;
        start_op(8'h80, 8'h01, 2'b11);
        repeat (4) tick();
        #2;
        rst = 1'b1;
        #1;
        total++; if (result !== 8'h00) begin bad++; $display("FAIL rst_mid_result got=%h exp=00", result); end
        total++; if ({cout, busy, done} !== 3'b000) begin bad++; $display("FAIL rst_mid_flags got=%b exp=000", {cout, busy, done}); end
        tick();
        rst = 1'b0;
        extra = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done || busy) extra++;
        end
        total++; if (extra !== 0) begin bad++; $display("FAIL rst_mid_done got=%0d exp=0", extra); end
        start_op(8'h03, 8'h04, 2'b10);
        wait_done(k);
        total++; if ({cout, result} !== 9'h007) begin bad++; $display("FAIL rst_after got=%b,%h exp=0,07", cout, result); end
        tick();
    endtask

    task automatic test_width2();
        int k;
        a2 = 2'b11; b2 = 2'b01; op2 = 2'b10; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        k = 0;
        do begin
            tick();
            k++;
        end while (!done2 && k < 40);
        total++; if (k !== 2) begin bad++; $display("FAIL w2_latency got=%0d exp=2", k); end
        total++; if ({cout2, result2} !== 3'b100) begin bad++; $display("FAIL w2_result got=%b,%b exp=1,00", cout2, result2); end
        tick();
        total++; if ({busy2, done2} !== 2'b00) begin bad++; $display("FAIL w2_idle got=%b exp=00", {busy2, done2}); end
    endtask

    task automatic test_random();
        int k;
        logic [7:0] ra, rb;
        logic [1:0] rop;
        logic [8:0] exp;
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rop = 2'($urandom_range(0, 3));
            case (rop)
                2'b00:   exp = {1'b0, ra & rb};
                2'b01:   exp = {1'b0, ra | rb};
                2'b10:   exp = {1'b0, ra} + {1'b0, rb};
                default: exp = {(ra < rb), 8'(ra - rb)};
            endcase
            start_op(ra, rb, rop);
            wait_done(k);
            total++;
            if (k !== 8 || {cout, result} !== exp) begin
                bad++;
                $display("FAIL rand op=%0d a=%h b=%h got=%b,%h lat=%0d exp=%b,%h lat=8",
                         rop, ra, rb, cout, result, k, exp[8], exp[7:0]);
            end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_add_basic();
        test_arith();
        test_back_to_back();
        test_ignore_start();
        test_rst_mid();
        test_width2();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
